// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller (master) and the datapath (slave).
// The master drives every control strobe and select; the slave returns the instruction fields.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_to_reg;
  logic       reg_dest;
  logic       i_or_d;
  logic       alu_src_a;
  logic       ir_write;
  logic       mem_write;
  logic       pc_write;
  logic       branch;
  logic       reg_write;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  modport master (
    input  opcode, funct,
    output mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
           pc_write, branch, reg_write, alu_src_b, pc_src, alu_control, state
  );

  modport slave (
    output opcode, funct,
    input  mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
           pc_write, branch, reg_write, alu_src_b, pc_src, alu_control, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath with a configurable fetch wait counter.
// Define MULTICYCLE_ADDI_EN to add the addi instruction (states ADDIEXEC/ADDIWB).
module multicycle_controller #(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
`endif
    JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dest;
    logic       i_or_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q;

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic ctrl_t ctrl_for(input state_e s, input logic [2:0] c, input logic [5:0] f);
    ctrl_t o;
    o             = '0;
    o.alu_control = ALU_ADD;
    case (s)
      FETCH: begin
        o.alu_src_b = 2'b01;
        o.ir_write  = (c == WAIT_LAST);
        o.pc_write  = (c == WAIT_LAST);
      end
      DECODE:   o.alu_src_b = 2'b11;
      MEMADR:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      MEMREAD:  o.i_or_d = 1'b1;
      MEMWB:    begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      MEMWRITE: begin o.i_or_d = 1'b1; o.mem_write = 1'b1; end
      EXECUTE:  begin o.alu_src_a = 1'b1; o.alu_control = funct_alu(f); end
      ALUWB:    begin o.reg_dest = 1'b1; o.reg_write = 1'b1; o.alu_control = funct_alu(f); end
      BRANCH: begin
        o.alu_src_a   = 1'b1;
        o.alu_control = ALU_SUB;
        o.pc_src      = 2'b01;
        o.branch      = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEXEC: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      ADDIWB:   o.reg_write = 1'b1;
`endif
      JUMP:     begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
      default:  ;
    endcase
    return o;
  endfunction

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = FETCH;
    cnt_d   = '0;
    case (state_q)
      FETCH: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = ADDIEXEC;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
`ifdef MULTICYCLE_ADDI_EN
      ADDIEXEC: state_d = ADDIWB;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // NOTE: outputs are registered by decoding the *next* state and counter, so they line up
  // with state_q in the same cycle while staying glitch-free; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      ctrl_q  <= ctrl_for(FETCH, 3'd0, bus.funct);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_for(state_d, cnt_d, bus.funct);
    end
  end

  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.reg_dest    = ctrl_q.reg_dest;
  assign bus.i_or_d      = ctrl_q.i_or_d;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.ir_write    = ctrl_q.ir_write;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.pc_write    = ctrl_q.pc_write;
  assign bus.branch      = ctrl_q.branch;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.pc_src      = ctrl_q.pc_src;
  assign bus.alu_control = ctrl_q.alu_control;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: one instance with FETCH_WAIT=0, one with FETCH_WAIT=3.
// Stimulus pushes the expected per-cycle state and control vector; a monitor pops and compares.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  multicycle_controller_if bus0 ();
  multicycle_controller_if bus1 ();

  multicycle_controller #(.FETCH_WAIT(0)) u_fw0 (.clk(clk), .reset(rst0), .bus(bus0));
  multicycle_controller #(.FETCH_WAIT(3)) u_fw3 (.clk(clk), .reset(rst1), .bus(bus1));

  typedef struct {
    logic [19:0] vec;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else             passes++;
  endtask

  // Expected {state, m2r, rd, iord, asa, irw, mw, pcw, br, rw, asb, pcs, alu}, written from the state table.
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input bit last, input logic [2:0] alu);
    logic m2r, rd, iod, asa, irw, mw, pcw, br, rw;
    logic [1:0] asb, pcs;
    logic [2:0] ac;
    {m2r, rd, iod, asa, irw, mw, pcw, br, rw} = '0;
    asb = 2'b00; pcs = 2'b00; ac = 3'b010;
    case (st)
      4'd0:  begin asb = 2'b01; irw = last; pcw = last; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iod = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iod = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; ac = alu; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; ac = alu; end
      4'd8:  begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {st, m2r, rd, iod, asa, irw, mw, pcw, br, rw, asb, pcs, ac};
  endfunction

  // seq lists states lowest nibble first; keep>0 stops after that many cycles and pulses reset.
  task automatic run(input int d, input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic [2:0] alu, input int n, input logic [23:0] seq, input int keep);
    int   fw;
    int   cycles;
    exp_t e;
    fw     = (d == 0) ? 0 : 3;
    cycles = 0;
    if (d == 0) begin bus0.opcode = op; bus0.funct = fn; end
    else        begin bus1.opcode = op; bus1.funct = fn; end
    for (int i = 0; i < n; i++) begin
      logic [3:0] st;
      st = seq[4*i +: 4];
      for (int k = 0; k <= ((st == 4'd0) ? fw : 0); k++) begin
        if (keep == 0 || cycles < keep) begin
          e.vec = exp_vec(st, (st != 4'd0) || (k == fw), alu);
          e.tag = $sformatf("%s.c%0d", tag, cycles);
          if (d == 0) q0.push_back(e); else q1.push_back(e);
          cycles++;
        end
      end
    end
    if (keep == 0) begin
      repeat (cycles) begin @(posedge clk); #1; end
    end else begin
      repeat (cycles - 1) begin @(posedge clk); #1; end
      if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
      @(posedge clk); #1;
      if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
    end
  endtask

  function automatic logic [19:0] act0();
    return {bus0.state, bus0.mem_to_reg, bus0.reg_dest, bus0.i_or_d, bus0.alu_src_a, bus0.ir_write,
            bus0.mem_write, bus0.pc_write, bus0.branch, bus0.reg_write, bus0.alu_src_b, bus0.pc_src,
            bus0.alu_control};
  endfunction

  function automatic logic [19:0] act1();
    return {bus1.state, bus1.mem_to_reg, bus1.reg_dest, bus1.i_or_d, bus1.alu_src_a, bus1.ir_write,
            bus1.mem_write, bus1.pc_write, bus1.branch, bus1.reg_write, bus1.alu_src_b, bus1.pc_src,
            bus1.alu_control};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); check({"fw0.", e.tag}, 32'(act0()), 32'(e.vec)); end
    if (q1.size() > 0) begin e = q1.pop_front(); check({"fw3.", e.tag}, 32'(act1()), 32'(e.vec)); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.opcode = '0; bus0.funct = '0;
    bus1.opcode = '0; bus1.funct = '0;
    @(posedge clk); #1;
    e.vec = exp_vec(4'd0, 1'b1, 3'b010); e.tag = "reset";
    q0.push_back(e);
    @(posedge clk); #1;
    rst0 = 1'b0;

    run(0, "slt",   6'b000000, 6'b101010, 3'b111, 4, 24'h7610,   0);
    run(0, "add",   6'b000000, 6'b100000, 3'b010, 4, 24'h7610,   0);
    run(0, "sub",   6'b000000, 6'b100010, 3'b110, 4, 24'h7610,   0);
    run(0, "and",   6'b000000, 6'b100100, 3'b000, 4, 24'h7610,   0);
    run(0, "or",    6'b000000, 6'b100101, 3'b001, 4, 24'h7610,   0);
    run(0, "badfn", 6'b000000, 6'b111111, 3'b010, 4, 24'h7610,   0);
    run(0, "lw",    6'b100011, 6'b000000, 3'b010, 5, 24'h43210,  0);
    run(0, "sw",    6'b101011, 6'b000000, 3'b010, 4, 24'h5210,   0);
    run(0, "beq",   6'b000100, 6'b000000, 3'b010, 3, 24'h810,    0);
    run(0, "j",     6'b000010, 6'b000000, 3'b010, 3, 24'hB10,    0);
`ifdef MULTICYCLE_ADDI_EN
    run(0, "addi",  6'b001000, 6'b000000, 3'b010, 4, 24'hA910,   0);
`else
    run(0, "addi",  6'b001000, 6'b000000, 3'b010, 2, 24'h10,     0);
`endif
    run(0, "illeg", 6'b111111, 6'b000000, 3'b010, 2, 24'h10,     0);
    run(0, "lwrst", 6'b100011, 6'b000000, 3'b010, 5, 24'h43210,  4);
    run(0, "illeg2",6'b111111, 6'b101010, 3'b010, 2, 24'h10,     0);
    run(0, "lw2",   6'b100011, 6'b000000, 3'b010, 5, 24'h43210,  0);

    rst1 = 1'b0;
    run(1, "j",     6'b000010, 6'b000000, 3'b010, 3, 24'hB10,    0);
    run(1, "lw",    6'b100011, 6'b000000, 3'b010, 5, 24'h43210,  0);
    run(1, "frst",  6'b100011, 6'b000000, 3'b010, 5, 24'h43210,  3);
    run(1, "j2",    6'b000010, 6'b000000, 3'b010, 3, 24'hB10,    0);
    run(1, "sub",   6'b000000, 6'b100010, 3'b110, 4, 24'h7610,   0);
    run(1, "beq",   6'b000100, 6'b000000, 3'b010, 3, 24'h810,    0);

    @(negedge clk); #1;
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
